// File: rtl/lsr_issue_wb.sv
// lsr_issue_wb: decodes LSR imm/reg, feeds the external ALU from a one-deep E stage,
// fixes up the ALU's out-of-range shift results and commits Rd plus NZC.
module lsr_issue_wb #(
   parameter logic [31:0]         RF_RESET       = 32'h0,
   parameter int                  ALU_OP_LEN     = 4,
   parameter logic [ALU_OP_LEN:0] ALU_OP_NOP     = '0,
   parameter logic [ALU_OP_LEN:0] ALU_OP_LSR_IMM = (ALU_OP_LEN+1)'(1),
   parameter logic [ALU_OP_LEN:0] ALU_OP_LSR_REG = (ALU_OP_LEN+1)'(2)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [15:0]           i_instr,
   input  logic                  i_instr_valid,
   output logic                  o_instr_ready,
   output logic [ALU_OP_LEN:0]   o_alu_op,
   output logic [31:0]           o_alu_rm,
   output logic [31:0]           o_alu_rs,
   output logic [31:0]           o_alu_rd,
   output logic [4:0]            o_alu_imm5,
   output logic                  o_alu_c,
   output logic                  o_alu_z,
   output logic                  o_alu_n,
   output logic                  o_alu_v,
   input  logic [31:0]           i_alu_rd,
   input  logic                  i_alu_c,
   input  logic                  i_alu_z,
   input  logic                  i_alu_n,
   input  logic [2:0]            i_dbg_addr,
   output logic [31:0]           o_dbg_data,
   output logic [3:0]            o_apsr,
   output logic                  o_fault
);
   typedef enum logic {RUN, FAULT} state_t;
   state_t      state;
   logic [31:0] rf [8];
   logic [3:0]  nzcv;
   logic        e_valid, e_imm;
   logic [31:0] e_rm, e_rd;
   logic [7:0]  e_sh;
   logic [2:0]  e_idx;
   logic        is_imm, is_reg, accept, lo, hi, c_n, z_n, n_n;
   logic [31:0] res, va, vb;
   always_comb begin
      is_imm = i_instr[15:11] == 5'b00001;
      is_reg = i_instr[15:6] == 10'b0100000011;
      accept = i_instr_valid && state == RUN;
      lo     = e_sh == 8'd0;
      hi     = e_sh >= 8'd32;
      res    = lo ? e_rm : hi ? 32'd0 : i_alu_rd;
      c_n    = lo ? nzcv[1] : hi ? (e_sh == 8'd32 && e_rm[31]) : i_alu_c;
      z_n    = lo ? (e_rm == 32'd0) : hi | i_alu_z;
      n_n    = lo ? e_rm[31] : !hi && i_alu_n;
      // a result still in E is newer than the array copy
      va     = (e_valid && e_idx == i_instr[5:3]) ? res : rf[i_instr[5:3]];
      vb     = (e_valid && e_idx == i_instr[2:0]) ? res : rf[i_instr[2:0]];
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= RUN;
         e_valid <= 1'b0;
         e_imm   <= 1'b0;
         e_rm    <= '0;
         e_rd    <= '0;
         e_sh    <= '0;
         e_idx   <= '0;
         nzcv    <= '0;
         for (int i = 0; i < 8; i++) rf[i] <= RF_RESET;
      end else begin
         e_valid <= accept && (is_imm || is_reg);
         if (accept && !(is_imm || is_reg)) state <= FAULT;
         if (accept && (is_imm || is_reg)) begin
            e_rm  <= is_imm ? va : vb;
            e_rd  <= vb;
            // imm5 of zero encodes a 32-bit shift, issued through the register form
            e_sh  <= !is_imm ? va[7:0] : i_instr[10:6] == 5'd0 ? 8'd32 : {3'b0, i_instr[10:6]};
            e_imm <= is_imm && i_instr[10:6] != 5'd0;
            e_idx <= i_instr[2:0];
         end
         if (e_valid) begin
            rf[e_idx] <= res;
            nzcv[3:1] <= {n_n, z_n, c_n};
         end
      end
   end
   assign o_instr_ready = state == RUN;
   assign o_fault       = state == FAULT;
   assign o_alu_op      = !e_valid ? ALU_OP_NOP : e_imm ? ALU_OP_LSR_IMM : ALU_OP_LSR_REG;
   assign o_alu_rm      = e_valid ? e_rm : 32'd0;
   assign o_alu_rd      = e_valid ? e_rd : 32'd0;
   assign o_alu_rs      = (e_valid && !e_imm) ? {24'd0, e_sh} : 32'd0;
   assign o_alu_imm5    = (e_valid && e_imm) ? e_sh[4:0] : 5'd0;
   assign {o_alu_n, o_alu_z, o_alu_c, o_alu_v} = nzcv;
   assign o_apsr        = nzcv;
   assign o_dbg_data    = rf[i_dbg_addr];
endmodule
